ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver with a configurable-depth receive FIFO, replacing the fixed 8-entry keyboard receiver. It filters and synchronises `ps2_clk`/`ps2_data` and decodes 11-bit frames with a state machine. It reports parity, framing and overflow errors separately. Received scan codes go to the host-side consumer (keyboard decoder / CPU MMIO) over a first-word-fall-through valid/ready interface.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/ps2_rx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM state encoding and frame constants.
package ps2_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_LVL  = 1'b0;
    localparam logic        STOP_LVL   = 1'b1;
    localparam logic        PARITY_ODD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // True when data bits plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return (^{d, p}) == PARITY_ODD;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered head, level, full and empty.
// Pointers carry one extra wrap bit; a write while full is accepted only alongside a read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             wr_acc_c, rd_acc_c;

    // Accept logic, next pointers and next head-of-queue value.
    always_comb begin
        rd_acc_c = rd_en_i && !empty_q;
        wr_acc_c = wr_en_i && (!full_q || rd_acc_c);
        wr_ptr_d = wr_ptr_q + PW'(wr_acc_c);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc_c);
        level_d  = level_q + PW'(wr_acc_c) - PW'(rd_acc_c);
        empty_d  = (level_d == '0);
        full_d   = (level_d == PW'(DEPTH));
        if (level_d == '0) begin
            head_d = '0;
        end else if (rd_ptr_d == wr_ptr_q) begin
            // Only the entry being written this cycle remains.
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data_o = head_q;
    assign valid_o   = !empty_q;
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign level_o   = level_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input synchronisers, ps2_clk glitch filter,
// 11-bit frame FSM and FWFT receive FIFO with sticky overflow.
// Optional mid-frame timeout abort is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          parity_err,
    output logic                          frame_err
);

    localparam int unsigned CW  = $clog2(FILT_LEN + 1);
    localparam int unsigned BCW = $clog2(DATA_BITS);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]           clk_sync_q, data_sync_q;
    logic                 clk_s, data_s;
    logic                 filt_q, filt_d;
    logic                 filt_dly_q;
    logic [CW-1:0]        filt_cnt_q, filt_cnt_d;
    logic                 smp_q;

    rx_state_e            state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic                 push_c;
    logic                 tmo_c;

    logic [7:0]           fifo_head;
    logic                 fifo_valid, fifo_empty, fifo_full;
    logic [LW-1:0]        fifo_level;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronisers, preset to the idle bus level.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Filtered level flips after FILT_LEN consecutive samples that disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + CW'(1);
            end
        end
    end

    // Filter state and the one-cycle sample strobe on a filtered falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            filt_cnt_q <= '0;
            smp_q      <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            filt_cnt_q <= filt_cnt_d;
            smp_q      <= filt_dly_q & ~filt_q;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Idle-cycle counter while a frame is in progress; a sample strobe takes priority.
    always_comb begin
        tmo_c     = (state_q != ST_IDLE) && !smp_q && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if ((state_q == ST_IDLE) || smp_q || tmo_c) begin
            tmo_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;

    assign tmo_c      = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    // Frame FSM: next state, shift register, push request and error pulses.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push_c    = 1'b0;
        if (smp_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_s == START_LVL) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s == STOP_LVL) begin
                        if (parity_ok(shift_q, par_q)) begin
                            push_c = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_c) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Sticky overflow: a push refused because the FIFO is full and no pop frees a slot.
    always_comb begin
        ovf_d = ovf_q & ~ovf_clr;
        if (push_c && fifo_full && !(ready && !fifo_empty)) begin
            ovf_d = 1'b1;
        end
    end

    // FSM, error pulse and overflow registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (clrn),
        .wr_en_i   (push_c),
        .wr_data_i (shift_q),
        .rd_en_i   (ready),
        .rd_data_o (fifo_head),
        .valid_o   (fifo_valid),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (fifo_level)
    );

    assign data       = fifo_head;
    assign valid      = fifo_valid;
    assign level      = fifo_level;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule
